// File: rtl/prog_sequencer.sv
//------------------------------------------------------------------------------
// Module   : prog_sequencer
// Purpose  : Run/halt sequencer that decodes jump/branch instructions through
//            a writable branch-target LUT, with a RUN-cycle watchdog.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module prog_sequencer #(
   parameter int PC_W       = 10,
   parameter int LUT_DEPTH  = 32,
   parameter int MAX_CYCLES = 1023
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_go,
   input  logic [PC_W-1:0] i_prog_ctr,
   input  logic [8:0]      i_instr,
   input  logic            i_alu_flag,
   input  logic            i_lut_we,
   input  logic [4:0]      i_lut_addr,
   input  logic [PC_W-1:0] i_lut_data,
   output logic            o_start,
   output logic            o_branch_abs_en,
   output logic [PC_W-1:0] o_target,
   output logic            o_busy,
   output logic            o_done,
   output logic            o_timeout_err,
   output logic [15:0]     o_cycle_count
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_RUN   = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   localparam logic [31:0] c_LIMIT      = 32'(MAX_CYCLES - 1);
   localparam logic [3:0]  c_OP_JMP     = 4'hD;
   localparam logic [3:0]  c_OP_BRF     = 4'hE;
   localparam logic [8:0]  c_HALT_INSTR = 9'h1FF;

   state_t          r_state;
   state_t          w_next;
   logic [PC_W-1:0] r_lut [LUT_DEPTH];
   logic [15:0]     r_cycle_count;
   logic            r_timeout_err;
   logic [PC_W-1:0] w_lut_rd;
   logic [3:0]      w_opcode;
   logic            w_at_limit;
   logic            w_set_timeout;
   logic            w_unused;

   // The program counter value is only brought in for observability.
   assign w_unused = ^i_prog_ctr;

   assign w_opcode   = i_instr[8:5];
   assign w_lut_rd   = r_lut[i_instr[4:0]];
   assign w_at_limit = (32'(r_cycle_count) == c_LIMIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LUT_DEPTH; i++) begin
            r_lut[i] <= '0;
         end
      end else if (i_lut_we) begin
         r_lut[i_lut_addr] <= i_lut_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next          = r_state;
      o_start         = 1'b0;
      o_busy          = 1'b0;
      o_done          = 1'b0;
      o_branch_abs_en = 1'b0;
      o_target        = '0;
      w_set_timeout   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_go) w_next = S_START;
         end
         S_START: begin
            o_start = 1'b1;
            w_next  = S_RUN;
         end
         S_RUN: begin
            o_busy = 1'b1;
            if (w_at_limit) begin
               w_next        = S_HALT;
               w_set_timeout = 1'b1;
            end
            // The halt word shadows the opcode decode even though its opcode is F.
            if (i_instr == c_HALT_INSTR) begin
               w_next = S_HALT;
            end else if (w_opcode == c_OP_JMP) begin
               o_branch_abs_en = 1'b1;
               o_target        = w_lut_rd;
            end else if (w_opcode == c_OP_BRF) begin
               o_branch_abs_en = i_alu_flag;
               o_target        = w_lut_rd;
            end
         end
         S_HALT: begin
            o_done = 1'b1;
            if (i_go) w_next = S_START;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Counts RUN cycles; the edge leaving RUN is counted too, so HALT shows the total.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cycle_count <= '0;
      end else if (w_next == S_START) begin
         r_cycle_count <= '0;
      end else if (r_state == S_RUN && r_cycle_count != 16'hFFFF) begin
         r_cycle_count <= r_cycle_count + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_timeout_err <= 1'b0;
      end else if (w_next == S_START) begin
         r_timeout_err <= 1'b0;
      end else if (w_set_timeout) begin
         r_timeout_err <= 1'b1;
      end
   end

   assign o_cycle_count = r_cycle_count;
   assign o_timeout_err = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_prog_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_prog_sequencer
// Purpose  : Directed scoreboard bench for prog_sequencer (MAX_CYCLES = 8).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_prog_sequencer;

   localparam int PC_W = 10;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            go;
   logic [PC_W-1:0] prog_ctr;
   logic [8:0]      instr;
   logic            flag;
   logic            we;
   logic [4:0]      addr;
   logic [PC_W-1:0] data;
   logic            start;
   logic            br;
   logic [PC_W-1:0] tgt;
   logic            busy;
   logic            done;
   logic            terr;
   logic [15:0]     cnt;

   typedef struct {
      int              cyc;
      string           name;
      logic            st;
      logic            br;
      logic [PC_W-1:0] tg;
      logic            bz;
      logic            dn;
      logic            te;
      logic [15:0]     cn;
   } exp_t;

   exp_t sb[$];
   exp_t e_mon;
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;

   prog_sequencer #(
      .PC_W       (PC_W),
      .LUT_DEPTH  (32),
      .MAX_CYCLES (8)
   ) u_dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_go            (go),
      .i_prog_ctr      (prog_ctr),
      .i_instr         (instr),
      .i_alu_flag      (flag),
      .i_lut_we        (we),
      .i_lut_addr      (addr),
      .i_lut_data      (data),
      .o_start         (start),
      .o_branch_abs_en (br),
      .o_target        (tgt),
      .o_busy          (busy),
      .o_done          (done),
      .o_timeout_err   (terr),
      .o_cycle_count   (cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e_mon = sb.pop_front();
         total++;
         if (e_mon.cyc < cyc) begin
            bad++;
            $display("FAIL %s: expectation for cycle %0d never sampled", e_mon.name, e_mon.cyc);
         end else if ({start, br, tgt, busy, done, terr, cnt} !==
                      {e_mon.st, e_mon.br, e_mon.tg, e_mon.bz, e_mon.dn, e_mon.te, e_mon.cn}) begin
            bad++;
            $display("FAIL %s cyc=%0d got st=%b br=%b tg=%0d bz=%b dn=%b te=%b cnt=%0d want st=%b br=%b tg=%0d bz=%b dn=%b te=%b cnt=%0d",
                     e_mon.name, cyc, start, br, tgt, busy, done, terr, cnt,
                     e_mon.st, e_mon.br, e_mon.tg, e_mon.bz, e_mon.dn, e_mon.te, e_mon.cn);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_o(input string nm, input logic st, input logic b,
                           input logic [PC_W-1:0] tg, input logic bz, input logic dn,
                           input logic te, input logic [15:0] cn);
      exp_t e;
      e.cyc  = cyc;
      e.name = nm;
      e.st   = st;
      e.br   = b;
      e.tg   = tg;
      e.bz   = bz;
      e.dn   = dn;
      e.te   = te;
      e.cn   = cn;
      sb.push_back(e);
   endtask

   initial begin
      rst_n = 1'b1; go = 1'b0; prog_ctr = '0; instr = '0; flag = 1'b0;
      we = 1'b0; addr = '0; data = '0;
      #2 rst_n = 1'b0;

      tick(); expect_o("reset", 0, 0, 0, 0, 0, 0, 0);
      tick(); rst_n = 1'b1; expect_o("idle_after_rst", 0, 0, 0, 0, 0, 0, 0);
      tick(); we = 1'b1; addr = 5'd3; data = 10'd10; expect_o("idle_lutwr3", 0, 0, 0, 0, 0, 0, 0);
      tick(); addr = 5'd4; data = 10'd5; expect_o("idle_lutwr4", 0, 0, 0, 0, 0, 0, 0);
      tick(); we = 1'b0; expect_o("idle_no_go", 0, 0, 0, 0, 0, 0, 0);
      tick(); go = 1'b1; expect_o("idle_go", 0, 0, 0, 0, 0, 0, 0);
      tick(); go = 1'b0; expect_o("start", 1, 0, 0, 0, 0, 0, 0);
      tick(); instr = 9'h000; expect_o("run_c0", 0, 0, 0, 1, 0, 0, 0);
      tick(); instr = 9'h1A3; go = 1'b1; expect_o("jump", 0, 1, 10, 1, 0, 0, 1);
      tick(); go = 1'b0; instr = 9'h1C4; flag = 1'b0;
      we = 1'b1; addr = 5'd4; data = 10'd7;
      expect_o("brf_flag0_oldlut", 0, 0, 5, 1, 0, 0, 2);
      tick(); we = 1'b0; flag = 1'b1; expect_o("brf_flag1_newlut", 0, 1, 7, 1, 0, 0, 3);
      tick(); instr = 9'h1FF; expect_o("halt_instr", 0, 0, 0, 1, 0, 0, 4);
      tick(); instr = 9'h000; flag = 1'b0; expect_o("halt", 0, 0, 0, 0, 1, 0, 5);
      tick(); expect_o("halt_hold", 0, 0, 0, 0, 1, 0, 5);
      tick(); go = 1'b1; expect_o("halt_go", 0, 0, 0, 0, 1, 0, 5);
      tick(); go = 1'b0; expect_o("restart", 1, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 8; k++) begin
         tick(); instr = 9'h0A3; expect_o("run_to_limit", 0, 0, 0, 1, 0, 0, 16'(k));
      end
      tick(); expect_o("timeout", 0, 0, 0, 0, 1, 1, 8);
      tick(); go = 1'b1; expect_o("timeout_sticky", 0, 0, 0, 0, 1, 1, 8);
      tick(); go = 1'b0; expect_o("timeout_cleared", 1, 0, 0, 0, 0, 0, 0);
      tick(); instr = 9'h1A3; expect_o("run2_jump", 0, 1, 10, 1, 0, 0, 0);
      tick(); #1 rst_n = 1'b0; expect_o("async_reset", 0, 0, 0, 0, 0, 0, 0);
      tick(); rst_n = 1'b1; expect_o("post_rst_idle", 0, 0, 0, 0, 0, 0, 0);
      tick(); expect_o("post_rst_wait", 0, 0, 0, 0, 0, 0, 0);
      tick(); go = 1'b1; expect_o("post_rst_go", 0, 0, 0, 0, 0, 0, 0);
      tick(); go = 1'b0; expect_o("post_rst_start", 1, 0, 0, 0, 0, 0, 0);
      tick(); expect_o("lut_cleared", 0, 1, 0, 1, 0, 0, 0);
      tick(); instr = 9'h1FF; expect_o("halt2_instr", 0, 0, 0, 1, 0, 0, 1);
      tick(); instr = 9'h000; expect_o("done2", 0, 0, 0, 0, 1, 0, 2);

      for (int w = 0; w < 20 && sb.size() > 0; w++) @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d expectations left, want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/prog_sequencer.md
PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 Parameter PC_W, default 10, program-counter and branch-target width.
REQ-002 Parameter LUT_DEPTH, default 32, number of branch-target lookup entries (index width 5).
REQ-003 Parameter MAX_CYCLES, default 1023, RUN-cycle limit before forced halt.
REQ-004 Clk  input  1  single clock; all state updates on rising edge.
REQ-005 Reset  input  1  asynchronous, active-low reset.
REQ-006 Go  input  1  request to run the program from address 0.
REQ-007 ProgCtr  input  PC_W  current instruction index from the program counter.
REQ-008 Instr  input  9  instruction word at ProgCtr; [8:5] opcode, [4:0] LUT index.
REQ-009 ALU_flag  input  1  branch condition from the ALU.
REQ-010 LutWe, LutAddr[4:0], LutData[PC_W-1:0]  input  write port for the target LUT.
REQ-011 Start  output  1  start strobe to the program counter.
REQ-012 BranchAbsEn  output  1  absolute-branch enable to the program counter.
REQ-013 Target  output  PC_W  absolute branch target to the program counter.
REQ-014 Busy, Done, TimeoutErr  output  1 each  status flags.
REQ-015 CycleCount  output  16  RUN cycles elapsed in the current program.

Function
REQ-016 The FSM SHALL have states IDLE, START, RUN and HALT.
REQ-017 IDLE: all strobes low; Go=1 -> START.
REQ-018 START SHALL last exactly one cycle with Start=1, then go to RUN; CycleCount is cleared on entry.
REQ-019 RUN: Busy=1, CycleCount increments by 1 per cycle and saturates at 16'hFFFF.
REQ-020 In RUN, opcode 4'hD (jump) SHALL drive BranchAbsEn=1 and Target=LUT[Instr[4:0]] combinationally in the same cycle.
REQ-021 In RUN, opcode 4'hE (branch-if-flag) SHALL assert BranchAbsEn only when ALU_flag=1; Target=LUT[Instr[4:0]] regardless of the flag.
REQ-022 For every other opcode in RUN, BranchAbsEn=0 and Target=0.
REQ-023 Instr=9'h1FF in RUN SHALL go to HALT on the next edge with BranchAbsEn=0; this takes priority over the opcode decode.
REQ-024 Outside RUN, BranchAbsEn=0 and Target=0.
REQ-025 When CycleCount equals MAX_CYCLES-1 in RUN, the FSM SHALL go to HALT and set TimeoutErr.
REQ-026 TimeoutErr SHALL be sticky until the next START.
REQ-027 HALT: Done=1, Busy=0, CycleCount frozen; Go=1 -> START, clearing Done and TimeoutErr.
REQ-028 Go in START or RUN SHALL be ignored.
REQ-029 LUT writes SHALL occur in any state and take effect on the next edge.
REQ-030 A same-cycle write and read of the same LUT index SHALL return the old value.
REQ-031 ProgCtr SHALL be used only for observation; no output depends on it.

Reset
REQ-032 Reset low SHALL immediately force IDLE and drive Start, BranchAbsEn, Busy, Done and TimeoutErr to 0, and Target and CycleCount to 0.
REQ-033 Reset low SHALL clear every LUT entry to 0.
REQ-034 Reset asserted mid-RUN SHALL abort the program with no Done pulse.
REQ-035 After Reset deasserts, the block SHALL stay in IDLE until Go is sampled high.

Verification
REQ-036 Go=1 for 1 cycle from IDLE -> Start=1 for exactly 1 cycle, then Busy=1, CycleCount=0 then 1.
REQ-037 LUT[3]=10, Instr=9'h1A3 (opcode D) in RUN -> BranchAbsEn=1, Target=10 in the same cycle.
REQ-038 LUT[4]=5, Instr=9'h1C4 (opcode E) -> ALU_flag=0: BranchAbsEn=0; ALU_flag=1: BranchAbsEn=1, Target=5.
REQ-039 Instr=9'h1FF in RUN -> HALT next edge, Done=1, Busy=0, CycleCount held; Go then restarts through START.
REQ-040 MAX_CYCLES=8 with no halt instruction -> HALT after 8 RUN cycles, TimeoutErr=1, cleared by the next Go.
REQ-041 Reset low mid-RUN (asynchronous, between edges) -> all outputs 0 immediately, LUT reads 0, Go required to restart.
